cskip_acc32: RTL and testbench
==============================

# cskip_acc32

Streaming 32-bit accumulator that sits directly upstream of result consumers and wraps a single combinational `CSkipA32` carry-skip adder instance. It accepts a frame of operands over a valid/ready handshake and sums them through the adder, with the running total fed back as adder input `a`. It tracks the adder's carry-out across the frame and presents the frame result over a second valid/ready handshake. Its purpose is to exercise the carry-skip adder in a real sequential datapath (multi-cycle sums, carry accumulation, back-pressure).

## Interface
- `NUM_OPS`, default 4: operands per frame, legal range 1..255; a frame may end earlier on `in_last`.
- `clk`  input  1: single clock, all state updates on rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: operand `in_data` is valid.
- `in_ready`  output  1: block accepts an operand this cycle.
- `in_data`  input  32: unsigned operand.
- `in_last`  input  1: qualifies `in_data` as the final operand of the frame (early termination).
- `out_valid`  output  1: frame result valid.
- `out_ready`  input  1: consumer accepts the result.
- `out_sum`  output  32: low 32 bits of the frame sum.
- `out_carries`  output  8: count of adder carry-outs in the frame, saturating at 255.
- `out_ovf`  output  1: sticky; set if any carry-out occurred in the frame.

## Operation
- Datapath: one `CSkipA32` instance, port order (sum, cout, a, b), no carry-in.
  - `a` = 0 in IDLE, `acc` in ACCUM.
  - `b` = `in_data`.
- Accept event: `in_valid && in_ready`.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On accept: `acc` <= sum, `cnt` <= 1, `carries` <= 0, `ovf` <= 0.
  - Next state is DONE if `in_last` or `NUM_OPS`==1; otherwise ACCUM.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - On accept: `acc` <= sum, `cnt` <= `cnt`+1.
  - If cout=1: `carries` <= min(`carries`+1, 255) and `ovf` <= 1.
  - Next state is DONE if `in_last` or `cnt`+1 == `NUM_OPS`.
  - No accept: all state holds.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`=`acc`, `out_carries`=`carries`, `out_ovf`=`ovf`.
  - `in_valid` and `in_data` are ignored.
  - On `out_valid && out_ready`: go to IDLE.
  - Outputs hold stable while `out_ready`=0.
- A cout from the first operand in IDLE cannot occur, because `a`=0.
- `in_last` is sampled only on an accept; its value on non-accept cycles is ignored.
- Reset:
  - All state clears: state=IDLE, `acc`=0, `cnt`=0, `carries`=0, `ovf`=0.
  - Reset output values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_carries`=0, `out_ovf`=0.
  - Reset asserted mid-frame or in DONE discards the partial frame or pending result; no output handshake completes in that cycle.

## Timing
- Adder path is combinational within one cycle; `acc` registered; no pipelining of the adder.
- `in_ready` and `out_valid` are pure functions of state (Moore); no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises the cycle after the final operand is accepted.
- Throughput: a frame of N operands with no stalls takes N accept cycles plus at least one DONE cycle, i.e. N+1 cycles per frame when `out_ready`=1.
- The first operand of the next frame is accepted no earlier than the cycle after the output handshake.
- Back-pressure in DONE extends DONE indefinitely; no operand is lost because `in_ready`=0.

## Test plan
- Reset, then hold `out_ready`=1:
  - NUM_OPS=4, operands 1, 2, 3, 4 on consecutive cycles.
  - Required: `out_valid` one cycle after the 4th accept; `out_sum`=0x0000000A, `out_carries`=0, `out_ovf`=0.
- Single carry, NUM_OPS=2:
  - Operands 0xA0A0FFFF, 0xA0BFFFE0.
  - Required: `out_sum`=0x4160FFDF, `out_carries`=1, `out_ovf`=1.
- Repeated carries, NUM_OPS=4:
  - Operands 0xFFFFFFFF ×4.
  - Required: `out_sum`=0xFFFFFFFC, `out_carries`=3, `out_ovf`=1.
- Early termination and input gaps, NUM_OPS=4:
  - Operand 5, then `in_valid`=0 for 2 cycles, then operand 7 with `in_last`=1.
  - Required: `out_sum`=0x0000000C, `out_carries`=0, DONE entered after 2 operands.
- Back-pressure:
  - In DONE hold `out_ready`=0 for 3 cycles while driving `in_valid`=1 with data 0x55.
  - Required: `in_ready`=0 and outputs stable throughout; after the handshake, IDLE, and the next frame sums from 0 (0x55 is not counted before that).
- Reset mid-frame:
  - NUM_OPS=4, accept 0x10 and 0x20, assert `rst` one cycle, then send 1, 1, 1, 1.
  - Required: `out_sum`=0x00000004, `out_carries`=0.

Source files
------------

// File: rtl/cskip_acc32_if.sv
// rtl/cskip_acc32_if.sv - operand-in / result-out handshake bundle for cskip_acc32
interface cskip_acc32_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic [7:0]  out_carries;
   logic        out_ovf;

   // Producer/consumer side: drives operands and result acceptance
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_carries, out_ovf
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_carries, out_ovf
   );
endinterface

// File: rtl/cskip_acc32.sv
// rtl/cskip_acc32.sv - streaming 32-bit frame accumulator around a carry-skip adder
module CSkipA32 (
   output logic [31:0] sum,
   output logic        cout,
   input  logic [31:0] a,
   input  logic [31:0] b
);
   logic [31:0] p;
   logic [31:0] g;
   logic [8:0]  blk_c;
   logic        rc;

   assign p = a ^ b;
   assign g = a & b;

   // Eight 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through
   always_comb begin
      sum   = '0;
      blk_c = '0;
      rc    = 1'b0;
      for (int blk = 0; blk < 8; blk++) begin
         rc = blk_c[blk];
         for (int i = 0; i < 4; i++) begin
            sum[blk*4+i] = p[blk*4+i] ^ rc;
            rc = g[blk*4+i] | (p[blk*4+i] & rc);
         end
         blk_c[blk+1] = (&p[blk*4 +: 4]) ? blk_c[blk] : rc;
      end
   end

   assign cout = blk_c[8];
endmodule

module cskip_acc32 #(
   parameter int NUM_OPS = 4
) (
   input  logic            clk,
   input  logic            rst,
   cskip_acc32_if.slave    bus
);
   localparam logic [8:0] NUM_OPS_W = 9'(NUM_OPS);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [7:0]  cnt;
   logic [7:0]  carries;
   logic        ovf;

   logic        rdy;
   logic        accept;
   logic [31:0] add_a;
   logic [31:0] add_sum;
   logic        add_cout;
   logic [8:0]  cnt_next;
   logic        frame_end;

   // The running total only feeds the adder once a frame is under way
   assign add_a = (state == ACCUM) ? acc : 32'd0;

   CSkipA32 u_add (
      .sum  (add_sum),
      .cout (add_cout),
      .a    (add_a),
      .b    (bus.in_data)
   );

   assign rdy       = (state != DONE);
   assign accept    = bus.in_valid && rdy;
   assign cnt_next  = (state == IDLE) ? 9'd1 : ({1'b0, cnt} + 9'd1);
   assign frame_end = bus.in_last || (cnt_next == NUM_OPS_W);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: if (accept) state_nxt = frame_end ? DONE : ACCUM;
         DONE:        if (bus.out_ready) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Moore outputs; result registers are presented directly
   always_comb begin
      bus.in_ready    = rdy;
      bus.out_valid   = (state == DONE);
      bus.out_sum     = acc;
      bus.out_carries = carries;
      bus.out_ovf     = ovf;
   end

   // Accumulator, operand count and carry statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         carries <= '0;
         ovf     <= 1'b0;
      end else if (accept) begin
         acc <= add_sum;
         cnt <= cnt_next[7:0];
         if (state == IDLE) begin
            carries <= '0;
            ovf     <= 1'b0;
         end else if (add_cout) begin
            if (carries != 8'hFF) carries <= carries + 8'd1;
            ovf <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cskip_acc32.sv
// tb/tb_cskip_acc32.sv - directed self-checking bench for cskip_acc32
module tb_cskip_acc32;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cskip_acc32_if bus ();

   cskip_acc32 #(.NUM_OPS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present one operand for exactly one cycle; it must be accepted
   task automatic send(input logic [31:0] d, input logic last);
      @(negedge clk);
      check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
      check("out_valid_before_send", 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(posedge clk);
   endtask

   // Result must be valid on the cycle right after the final accept, then handshake
   task automatic expect_result(input string tag, input logic [31:0] sum,
                                input logic [7:0] car, input logic ovf);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_sum"}, bus.out_sum, sum);
      check({tag, "_carries"}, 32'(bus.out_carries), 32'(car));
      check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_back_idle"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_sum", bus.out_sum, 32'd0);
      check("rst_out_carries", 32'(bus.out_carries), 32'd0);
      check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
      rst = 1'b0;

      // Four small operands back to back, frame closed by the count
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b0);
      send(32'd4, 1'b0);
      expect_result("basic", 32'h0000_000A, 8'd0, 1'b0);

      // Two operands producing one carry-out, closed by in_last
      send(32'hA0A0_FFFF, 1'b0);
      send(32'hA0BF_FFE0, 1'b1);
      expect_result("one_carry", 32'h4160_FFDF, 8'd1, 1'b1);

      // All-ones operands: every add after the first carries
      for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0);
      expect_result("rep_carry", 32'hFFFF_FFFC, 8'd3, 1'b1);

      // Gaps with in_last high while idle-valid must not close the frame
      send(32'd5, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b1;
         check("gap_out_valid", 32'(bus.out_valid), 32'd0);
         check("gap_in_ready", 32'(bus.in_ready), 32'd1);
         @(posedge clk);
      end
      send(32'd7, 1'b1);
      expect_result("early_last", 32'h0000_000C, 8'd0, 1'b0);

      // Back-pressure in DONE with a stray operand offered
      send(32'd8, 1'b0);
      send(32'd9, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b1;
         bus.in_last   = 1'b0;
         bus.in_data   = 32'h55;
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         check("bp_out_sum", bus.out_sum, 32'h11);
         check("bp_out_carries", 32'(bus.out_carries), 32'd0);
         check("bp_out_ovf", 32'(bus.out_ovf), 32'd0);
         @(posedge clk);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      check("bp_release_valid", 32'(bus.out_valid), 32'd1);
      check("bp_release_sum", bus.out_sum, 32'h11);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_after_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_after_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      send(32'd3, 1'b0);
      send(32'd4, 1'b1);
      expect_result("after_bp", 32'h0000_0007, 8'd0, 1'b0);

      // Reset mid-frame discards the partial sum
      send(32'h10, 1'b0);
      send(32'h20, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_sum", bus.out_sum, 32'd0);
      for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
      expect_result("after_midrst", 32'h0000_0004, 8'd0, 1'b0);

      // Reset while a result is pending drops it
      send(32'd9, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("done_rst_pre_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("done_rst_out_sum", bus.out_sum, 32'd0);
      check("done_rst_in_ready", 32'(bus.in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
